// File: rtl/cosine_arbiter.sv
// Shares one cosine core between NUM_REQ requesters.
// Round-robin grant, one job in flight, watchdog on core done.
module cosine_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 32,
  parameter int MAX_LAT = 16,
  parameter logic [DATA_W-1:0] TIMEOUT_RESULT = 32'h7FC00000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic [NUM_REQ-1:0]        req_start,
  input  logic [NUM_REQ*DATA_W-1:0] req_theta,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ*DATA_W-1:0] req_result,
  output logic [NUM_REQ-1:0]        req_pending,
  output logic                      core_clk_en,
  output logic                      core_start,
  output logic [DATA_W-1:0]         core_theta,
  input  logic                      core_done,
  input  logic [DATA_W-1:0]         core_result,
  output logic                      err_timeout
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  state_e                      state_q, state_d;
  logic [NUM_REQ-1:0]          pending_q, pending_d;
  logic [DATA_W-1:0]           theta_q [NUM_REQ];
  logic [DATA_W-1:0]           theta_d [NUM_REQ];
  logic [GW-1:0]               grant_q, grant_d;
  logic [GW-1:0]               last_q, last_d;
  logic [DATA_W-1:0]           core_theta_q, core_theta_d;
  logic [NUM_REQ-1:0]          done_q, done_d;
  logic [NUM_REQ*DATA_W-1:0]   result_q, result_d;
  logic [WW-1:0]               wd_q, wd_d;
  logic                        err_q, err_d;
  logic [NUM_REQ-1:0]          clr;
  logic                        found;
  logic [GW-1:0]               pick;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    theta_d      = theta_q;
    grant_d      = grant_q;
    last_d       = last_q;
    core_theta_d = core_theta_q;
    done_d       = '0;
    result_d     = result_q;
    wd_d         = wd_q;
    err_d        = err_q;
    clr          = '0;
    found        = 1'b0;
    pick         = '0;

    // cyclic search starting just after the last served requester
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d      = pick;
          core_theta_d = theta_q[pick];
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          result_d[int'(grant_q)*DATA_W +: DATA_W] = core_result;
          done_d[grant_q] = 1'b1;
          clr[grant_q]    = 1'b1;
          last_d          = grant_q;
          state_d         = IDLE;
        end else if (wd_q == WW'(MAX_LAT - 1)) begin
          result_d[int'(grant_q)*DATA_W +: DATA_W] = TIMEOUT_RESULT;
          done_d[grant_q] = 1'b1;
          clr[grant_q]    = 1'b1;
          last_d          = grant_q;
          err_d           = 1'b1;
          state_d         = IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // a completing slot may take a fresh request on the same edge
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_start[i] && (!pending_q[i] || clr[i])) begin
        pending_d[i] = 1'b1;
        theta_d[i]   = req_theta[i*DATA_W +: DATA_W];
      end else if (clr[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      for (int i = 0; i < NUM_REQ; i++) theta_q[i] <= '0;
      grant_q      <= '0;
      last_q       <= GW'(NUM_REQ - 1);
      core_theta_q <= '0;
      done_q       <= '0;
      result_q     <= '0;
      wd_q         <= '0;
      err_q        <= 1'b0;
    end else if (clk_en) begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      theta_q      <= theta_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      core_theta_q <= core_theta_d;
      done_q       <= done_d;
      result_q     <= result_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
    end
  end

  assign core_clk_en = clk_en;
  assign core_start  = (state_q == ISSUE);
  assign core_theta  = core_theta_q;
  assign req_done    = done_q;
  assign req_result  = result_q;
  assign req_pending = pending_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_cosine_arbiter.sv
// Bench for cosine_arbiter: behavioural core, round-robin
// reference model, directed and random jobs.
module tb_cosine_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int BW = N * W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clk_en;
  logic [N-1:0]   req_start;
  logic [BW-1:0]  req_theta;
  logic [N-1:0]   req_done;
  logic [BW-1:0]  req_result;
  logic [N-1:0]   req_pending;
  logic           core_clk_en;
  logic           core_start;
  logic [W-1:0]   core_theta;
  logic           core_done;
  logic [W-1:0]   core_result;
  logic           err_timeout;

  cosine_arbiter dut (
    .clk(clk), .reset(rst_n), .clk_en(clk_en),
    .req_start(req_start), .req_theta(req_theta),
    .req_done(req_done), .req_result(req_result),
    .req_pending(req_pending), .core_clk_en(core_clk_en),
    .core_start(core_start), .core_theta(core_theta),
    .core_done(core_done), .core_result(core_result),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // behavioural core: done 'lat' enabled cycles after start
  logic         m_done;
  logic [W-1:0] m_res;
  logic [W-1:0] m_th;
  int           m_cnt;
  bit           m_busy;
  int           lat = 4;
  bit           hang = 1'b0;
  logic         inj_done = 1'b0;
  int           n_starts = 0;

  function automatic logic [W-1:0] f(input logic [W-1:0] x);
    return x ^ 32'h8000_5A5A;
  endfunction

  assign core_done   = m_done | inj_done;
  assign core_result = m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
      m_th   <= '0;
    end else if (clk_en) begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt <= 1) begin
          m_done <= 1'b1;
          m_res  <= f(m_th);
          m_busy <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (core_start) n_starts <= n_starts + 1;
      if (core_start && !hang) begin
        m_busy <= 1'b1;
        m_cnt  <= lat;
        m_th   <= core_theta;
      end
    end
  end

  // reference model state
  int           n_chk = 0;
  int           n_pass = 0;
  int           m_last;
  bit [N-1:0]   mp;
  logic [W-1:0] mth [N];
  logic [W-1:0] th [N];

  function automatic int rr_pick(input bit [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++)
      if (m[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] obs,
                       input logic [BW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic [N-1:0] m);
    req_start = m;
    for (int i = 0; i < N; i++) begin
      req_theta[i*W +: W] = th[i];
      if (m[i] && !mp[i]) begin
        mp[i]  = 1'b1;
        mth[i] = th[i];
      end
    end
    tick();
    req_start = '0;
  endtask

  task automatic wait_done(input int max, output int idx,
                           output logic [W-1:0] res, output int t);
    idx = -1;
    res = '0;
    t   = 0;
    while (idx < 0 && t < max) begin
      tick();
      t++;
      for (int i = N - 1; i >= 0; i--)
        if (req_done[i]) idx = i;
    end
    if (idx >= 0) res = req_result[idx*W +: W];
  endtask

  task automatic take(output int t);
    int e, idx;
    logic [W-1:0] res;
    e = rr_pick(mp, m_last);
    wait_done(200, idx, res, t);
    check("order", BW'(idx), BW'(e));
    if (e >= 0) begin
      check("result", BW'(res), BW'(f(mth[e])));
      mp[e]  = 1'b0;
      m_last = e;
    end
  endtask

  task automatic take_n(input int n);
    int t;
    repeat (n) take(t);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_last = N - 1;
    mp = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int s0, t0, t1, idx, e, cnt;
    logic [W-1:0] res, a;
    logic [N-1:0] msk;

    rst_n = 1'b0;
    clk_en = 1'b1;
    req_start = '0;
    req_theta = '0;
    for (int i = 0; i < N; i++) th[i] = '0;
    repeat (2) tick();
    check("rst_done", BW'(req_done), '0);
    check("rst_pending", BW'(req_pending), '0);
    check("rst_result", req_result, '0);
    check("rst_start", BW'(core_start), '0);
    check("rst_theta", BW'(core_theta), '0);
    check("rst_err", BW'(err_timeout), '0);
    rst_n = 1'b1;
    m_last = N - 1;
    mp = '0;

    // single request
    th[0] = 32'hBF800000;
    s0 = n_starts;
    issue(4'b0001);
    check("single_pend", BW'(req_pending), BW'(4'b0001));
    check("single_nostart", BW'(core_start), '0);
    tick();
    check("single_start", BW'(core_start), BW'(1));
    check("single_theta", BW'(core_theta), BW'(32'hBF800000));
    tick();
    check("single_start_low", BW'(core_start), '0);
    wait_done(50, idx, res, t0);
    check("single_done_bits", BW'(req_done), BW'(4'b0001));
    check("single_res", BW'(res), BW'(f(32'hBF800000)));
    tick();
    check("single_done_low", BW'(req_done), '0);
    check("single_pend_clr", BW'(req_pending), '0);
    check("single_nstarts", BW'(n_starts - s0), BW'(1));
    mp = '0;
    m_last = 0;

    // contention from reset
    do_reset();
    th[0] = 32'h3F800000;
    th[1] = 32'h40000000;
    th[2] = 32'h40400000;
    th[3] = 32'h40800000;
    s0 = n_starts;
    issue(4'b1111);
    take_n(4);
    check("cont_nstarts", BW'(n_starts - s0), BW'(4));

    // round robin: 1, then {0,2} -> 2 before 0
    th[1] = $urandom;
    issue(4'b0010);
    take_n(1);
    th[0] = $urandom;
    th[2] = $urandom;
    issue(4'b0101);
    take_n(2);

    // duplicate start while pending is ignored
    s0 = n_starts;
    th[1] = $urandom;
    issue(4'b0010);
    a = $urandom;
    req_start = 4'b0010;
    req_theta[W +: W] = a;
    tick();
    req_start = '0;
    take_n(1);
    cnt = 0;
    repeat (20) begin
      tick();
      if (|req_done) cnt++;
    end
    check("dup_extra", BW'(cnt), '0);
    check("dup_nstarts", BW'(n_starts - s0), BW'(1));

    // new start on the completion edge is accepted
    th[1] = $urandom;
    issue(4'b0010);
    cnt = 0;
    while (!core_done && cnt < 50) begin
      tick();
      cnt++;
    end
    check("b2b_core_done", BW'(core_done), BW'(1));
    a = $urandom;
    req_start = 4'b0010;
    req_theta[W +: W] = a;
    tick();
    req_start = '0;
    check("b2b_done", BW'(req_done), BW'(4'b0010));
    check("b2b_res", BW'(req_result[W +: W]), BW'(f(mth[1])));
    check("b2b_pend", BW'(req_pending), BW'(4'b0010));
    m_last = 1;
    mth[1] = a;
    take_n(1);

    // clk_en gating delays completion by the gap
    th[3] = $urandom;
    issue(4'b1000);
    take(t0);
    th[3] = $urandom;
    issue(4'b1000);
    repeat (3) tick();
    clk_en = 1'b0;
    repeat (3) begin
      tick();
      check("gate_core_en", BW'(core_clk_en), '0);
      check("gate_pend", BW'(req_pending), BW'(4'b1000));
    end
    clk_en = 1'b1;
    take(t1);
    check("gate_delay", BW'(t1 + 6 - t0), BW'(3));

    // done pulse stretches while disabled
    th[0] = $urandom;
    issue(4'b0001);
    e = rr_pick(mp, m_last);
    wait_done(50, idx, res, t0);
    check("hold_idx", BW'(idx), BW'(e));
    clk_en = 1'b0;
    repeat (2) begin
      tick();
      check("hold_done", BW'(req_done), BW'(4'b0001));
    end
    clk_en = 1'b1;
    tick();
    check("hold_release", BW'(req_done), '0);
    mp[0] = 1'b0;
    m_last = 0;

    // watchdog timeout, then the next job still runs
    hang = 1'b1;
    th[0] = $urandom;
    th[2] = $urandom;
    issue(4'b0101);
    e = rr_pick(mp, m_last);
    cnt = 0;
    while (!core_start && cnt < 20) begin
      tick();
      cnt++;
    end
    tick();
    wait_done(40, idx, res, t0);
    hang = 1'b0;
    check("to_wait", BW'(t0), BW'(16));
    check("to_idx", BW'(idx), BW'(e));
    check("to_res", BW'(res), BW'(32'h7FC00000));
    check("to_err", BW'(err_timeout), BW'(1));
    if (e >= 0) begin
      mp[e] = 1'b0;
      m_last = e;
    end
    take_n(1);
    check("to_err_sticky", BW'(err_timeout), BW'(1));
    a = req_result[2*W +: W];
    inj_done = 1'b1;
    repeat (2) tick();
    inj_done = 1'b0;
    cnt = 0;
    repeat (5) begin
      tick();
      if (|req_done) cnt++;
    end
    check("late_done", BW'(cnt), '0);
    check("late_res", BW'(req_result[2*W +: W]), BW'(a));

    // asynchronous reset in the middle of WAIT
    hang = 1'b1;
    th[3] = $urandom;
    issue(4'b1000);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("ar_pend", BW'(req_pending), '0);
    check("ar_start", BW'(core_start), '0);
    check("ar_theta", BW'(core_theta), '0);
    check("ar_err", BW'(err_timeout), '0);
    check("ar_result", req_result, '0);
    tick();
    rst_n = 1'b1;
    hang = 1'b0;
    m_last = N - 1;
    mp = '0;

    // random jobs against the reference model
    repeat (8) begin
      msk = 4'($urandom_range(1, 15));
      lat = $urandom_range(1, 6);
      for (int i = 0; i < N; i++) th[i] = $urandom;
      issue(msk);
      take_n($countones(msk));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
